// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             cnt_clear;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_memread, ex_rd, ex_branch_taken,
    output imem_ready, cnt_clear,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
    input  state, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_memread, ex_rd, ex_branch_taken,
    input  imem_ready, cnt_clear,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
    output state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, instruction-memory wait states and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int LU_CYCLES    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_IMEM_WAIT  = 2'd3
  } state_t;

  localparam logic [3:0]       LU_INIT    = 4'(LU_CYCLES - 1);
  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hz;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign hz = bus.ex_valid & bus.ex_memread & (bus.ex_rd != 5'd0) & bus.id_valid &
              ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
               (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;

    if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES == 1) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_INIT;
      end
    end else begin
      case (state_q)
        ST_LOAD_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = bus.imem_ready ? ST_RUN : ST_IMEM_WAIT;
          end
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN, ST_IMEM_WAIT: begin
          // A wait state only leaves once the fetch lands; then it acts as RUN.
          if (state_q == ST_IMEM_WAIT && !bus.imem_ready) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end else if (hz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LU_CYCLES == 1) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_LOAD_STALL;
              cnt_d   = LU_INIT;
            end
          end else if (!bus.imem_ready) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_IMEM_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write && stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (ifid_flush && flush_cnt_q != CNT_MAX) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  // While reset is held the pipeline is frozen and fed NOPs.
  always_comb begin
    if (!rst_n) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else begin
      bus.pc_write    = pc_write;
      bus.ifid_write  = ifid_write;
      bus.ifid_flush  = ifid_flush;
      bus.idex_bubble = idex_bubble;
    end
  end

  assign bus.state       = state_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hc_if ();

  pipeline_hazard_ctrl #(
    .LU_CYCLES   (2),
    .FLUSH_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (hc_if)
  );

  typedef struct {
    string       name;
    logic        pc;
    logic        ifw;
    logic        ifl;
    logic        bub;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: the controller presents a response every cycle; compare on negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".pc_write"},    32'(hc_if.pc_write),    32'(e.pc));
        chk({e.name, ".ifid_write"},  32'(hc_if.ifid_write),  32'(e.ifw));
        chk({e.name, ".ifid_flush"},  32'(hc_if.ifid_flush),  32'(e.ifl));
        chk({e.name, ".idex_bubble"}, 32'(hc_if.idex_bubble), 32'(e.bub));
        chk({e.name, ".state"},       32'(hc_if.state),       32'(e.st));
        chk({e.name, ".stall_count"}, 32'(hc_if.stall_count), 32'(e.sc));
        chk({e.name, ".flush_count"}, 32'(hc_if.flush_count), 32'(e.fc));
        $display("cycle %-10s pc=%0b ifw=%0b fl=%0b bub=%0b st=%0d stall=%0d flush=%0d",
                 e.name, hc_if.pc_write, hc_if.ifid_write, hc_if.ifid_flush,
                 hc_if.idex_bubble, hc_if.state, hc_if.stall_count, hc_if.flush_count);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic idv, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic exv, input logic mr,
                        input logic [4:0] rd, input logic br, input logic im, input logic clr);
    hc_if.id_valid        = idv;
    hc_if.id_rs1          = r1;
    hc_if.id_rs2          = r2;
    hc_if.id_uses_rs1     = u1;
    hc_if.id_uses_rs2     = u2;
    hc_if.ex_valid        = exv;
    hc_if.ex_memread      = mr;
    hc_if.ex_rd           = rd;
    hc_if.ex_branch_taken = br;
    hc_if.imem_ready      = im;
    hc_if.cnt_clear       = clr;
  endtask

  task automatic push(input string nm, input logic pc, input logic ifw, input logic ifl,
                      input logic bub, input logic [1:0] st, input int sc, input int fc);
    exp_t e;
    e.name = nm; e.pc = pc; e.ifw = ifw; e.ifl = ifl; e.bub = bub;
    e.st = st; e.sc = 16'(sc); e.fc = 16'(fc);
    exp_q.push_back(e);
  endtask

  // Common vectors
  task automatic idle();          set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic lu_rs2(input logic im); set_in(1, 0, 5, 0, 1, 1, 1, 5, 0, im, 0); endtask
  task automatic imem_wait();     set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick(); push("rst", 0, 0, 1, 1, 0, 0, 0);
    end
    tick(); rst_n = 1'b1; push("rel1", 1, 1, 0, 0, 0, 0, 0);
    tick(); push("rel2", 1, 1, 0, 0, 0, 0, 0);

    // Load-use on rs2: two stall cycles, 0 -> 1 -> 0
    tick(); lu_rs2(1); push("lu1", 0, 0, 0, 1, 0, 0, 0);
    tick(); push("lu2", 0, 0, 0, 1, 1, 1, 0);
    tick(); idle(); push("lu3", 1, 1, 0, 0, 0, 2, 0);

    // x0 never hazards
    tick(); set_in(1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0); push("x0a", 1, 1, 0, 0, 0, 2, 0);
    tick(); push("x0b", 1, 1, 0, 0, 0, 2, 0);

    // Branch in the LOAD_STALL cycle aborts the stall
    tick(); lu_rs2(1); push("bs1", 0, 0, 0, 1, 0, 2, 0);
    tick(); set_in(1, 0, 5, 0, 1, 1, 1, 5, 1, 1, 0); push("bs2", 1, 1, 1, 1, 1, 3, 0);
    tick(); idle(); push("bs3", 1, 1, 1, 1, 2, 3, 1);
    tick(); push("bs4", 1, 1, 0, 0, 0, 3, 2);

    // Counter clear
    tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); push("clr1", 1, 1, 0, 0, 0, 3, 2);
    tick(); idle(); push("clr2", 1, 1, 0, 0, 0, 0, 0);

    // Instruction-memory wait, then a hazard on the cycle the fetch lands
    tick(); imem_wait(); push("iw1", 0, 0, 0, 1, 0, 0, 0);
    tick(); push("iw2", 0, 0, 0, 1, 3, 1, 0);
    tick(); push("iw3", 0, 0, 0, 1, 3, 2, 0);
    tick(); push("iw4", 0, 0, 0, 1, 3, 3, 0);
    tick(); lu_rs2(1); push("iw5", 0, 0, 0, 1, 3, 4, 0);
    tick(); idle(); push("iw6", 0, 0, 0, 1, 1, 5, 0);
    tick(); push("iw7", 1, 1, 0, 0, 0, 6, 0);

    // Load stall ending while imem is not ready goes to IMEM_WAIT
    tick(); lu_rs2(1); push("lw1", 0, 0, 0, 1, 0, 6, 0);
    tick(); imem_wait(); push("lw2", 0, 0, 0, 1, 1, 7, 0);
    tick(); push("lw3", 0, 0, 0, 1, 3, 8, 0);
    tick(); idle(); push("lw4", 1, 1, 0, 0, 3, 9, 0);
    tick(); push("lw5", 1, 1, 0, 0, 0, 9, 0);

    // Branch aborts IMEM_WAIT; FLUSH ignores imem_ready
    tick(); imem_wait(); push("bw1", 0, 0, 0, 1, 0, 9, 0);
    tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); push("bw2", 1, 1, 1, 1, 3, 10, 0);
    tick(); imem_wait(); push("bw3", 1, 1, 1, 1, 2, 10, 1);
    tick(); idle(); push("bw4", 1, 1, 0, 0, 0, 10, 2);

    // rs1 hazard, and near-misses that must not stall
    tick(); set_in(1, 7, 0, 1, 0, 1, 1, 7, 0, 1, 0); push("rs1a", 0, 0, 0, 1, 0, 10, 2);
    tick(); idle(); push("rs1b", 0, 0, 0, 1, 1, 11, 2);
    tick(); set_in(1, 7, 0, 1, 0, 1, 0, 7, 0, 1, 0); push("nold", 1, 1, 0, 0, 0, 12, 2);
    tick(); set_in(1, 7, 0, 0, 0, 1, 1, 7, 0, 1, 0); push("nouse", 1, 1, 0, 0, 0, 12, 2);
    tick(); set_in(0, 7, 0, 1, 0, 1, 1, 7, 0, 1, 0); push("noidv", 1, 1, 0, 0, 0, 12, 2);

    // Reset asserted mid-stall
    tick(); lu_rs2(1); push("mr1", 0, 0, 0, 1, 0, 12, 2);
    tick(); rst_n = 1'b0; push("mr2", 0, 0, 1, 1, 0, 0, 0);
    tick(); rst_n = 1'b1; idle(); push("mr3", 1, 1, 0, 0, 0, 0, 0);

    // Saturation of stall_count
    tick(); imem_wait();
    for (int i = 0; i < 65540; i++) tick();
    push("sat1", 0, 0, 0, 1, 3, 65535, 0);
    tick(); push("sat2", 0, 0, 0, 1, 3, 65535, 0);
    tick(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); push("sclr1", 0, 0, 0, 1, 3, 65535, 0);
    tick(); imem_wait(); push("sclr2", 0, 0, 0, 1, 3, 0, 0);
    tick(); push("sclr3", 0, 0, 0, 1, 3, 1, 0);

    tick();
    tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 32-bit pipeline.
- Detects load-use hazards between the ID and EX stages, handles taken-branch flushes and instruction-memory wait states.
- Drives the write enables, flush and bubble controls of the PC, IF/ID and ID/EX registers.
- Keeps saturating stall and flush performance counters.

Parameters:
LU_CYCLES, 2, total stall cycles for a load-use hazard, including the detection cycle; legal range 1..15.
FLUSH_CYCLES, 2, total cycles ifid_flush is held after a taken branch, including the branch cycle; legal range 1..15.
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
id_valid  input  1  ID stage holds a real instruction.
id_rs1  input  5  ID source register 1.
id_rs2  input  5  ID source register 2.
id_uses_rs1  input  1  ID instruction reads rs1.
id_uses_rs2  input  1  ID instruction reads rs2.
ex_valid  input  1  EX stage holds a real instruction.
ex_memread  input  1  EX instruction is a load.
ex_rd  input  5  EX destination register.
ex_branch_taken  input  1  EX resolved a taken branch or jump.
imem_ready  input  1  instruction memory delivers a fetch this cycle.
cnt_clear  input  1  synchronous clear of both counters.
pc_write  output  1  PC register load enable.
ifid_write  output  1  IF/ID register load enable.
ifid_flush  output  1  IF/ID contents become a NOP.
idex_bubble  output  1  ID/EX loads a NOP.
state  output  2  current state: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 IMEM_WAIT.
stall_count  output  CNT_W  cycles with pc_write=0.
flush_count  output  CNT_W  cycles with ifid_flush=1.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous and active-low.
- While rst_n=0:
  - state=RUN, internal counter=0, stall_count=0, flush_count=0.
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- Output timing: control outputs are combinational from state, internal counter and current inputs, so a hazard stalls in the same cycle it is detected. State and counters are registered.
- Hazard term: hz = ex_valid & ex_memread & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Register x0 never causes a hazard.
- Priority, evaluated in every state: ex_branch_taken > hz / LOAD_STALL > imem_ready=0.
- Branch (any state): outputs pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
  - FLUSH_CYCLES=1 → next state RUN.
  - Otherwise → next state FLUSH with counter=FLUSH_CYCLES-1.
  - A branch aborts any LOAD_STALL or IMEM_WAIT in progress.
- RUN:
  - hz: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1. LU_CYCLES=1 → stay RUN; else → LOAD_STALL with counter=LU_CYCLES-1.
  - else if imem_ready=0: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1 → IMEM_WAIT.
  - else: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- LOAD_STALL: outputs as in the RUN hz case; hz and imem_ready are ignored. Counter decrements each cycle. On the cycle counter==1, next state is RUN if imem_ready=1, else IMEM_WAIT.
- FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. The fetched instruction is discarded regardless of imem_ready. Counter decrements; counter==1 → RUN.
- IMEM_WAIT:
  - imem_ready=0: stall outputs as in RUN with imem_ready=0; stay.
  - imem_ready=1: evaluate exactly as RUN for this cycle, including the hz check, and take RUN's next-state transitions.
- stall_count: +1 on every clock edge where pc_write=0 (post-reset). Saturates at all-ones; no wrap.
- flush_count: +1 on every edge where ifid_flush=1. Saturates at all-ones.
- cnt_clear=1: both counters load 0 on that edge, overriding any increment that cycle.
- Reset asserted mid-stall or mid-flush: immediate return to the reset values above. No pending operation resumes after reset.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with imem_ready=1 and no hazards → state=0 and pc_write=ifid_write=1 from the first cycle after release; both counters stay 0.
- Load-use: ex_valid=1, ex_memread=1, ex_rd=5, id_valid=1, id_uses_rs2=1, id_rs2=5 → pc_write=0 and idex_bubble=1 for exactly 2 cycles (state 0→1→0); stall_count=2.
- x0 immunity: same stimulus with ex_rd=0, id_rs1=0 → no stall, pc_write stays 1.
- Branch during stall: ex_branch_taken=1 in the second LOAD_STALL cycle → ifid_flush=1 and pc_write=1 that cycle and the next (FLUSH), then RUN; flush_count=2.
- IMEM wait: imem_ready=0 for 4 cycles → state=3 and pc_write=0 for 4 cycles; on imem_ready=1 with a hazard present, the cycle behaves as a load-use stall and the next state is LOAD_STALL.
- Counter limits: force 65535 stall cycles → stall_count=0xFFFF and holds; pulse cnt_clear in a stall cycle → stall_count=0 on that edge.
